dp_skid_reg: RTL

DP_SKID_REG -- requirements
Module: dp_skid_reg

---
 rtl/dp_skid_reg.sv | 77 +++++++
 1 files changed

// File: rtl/dp_skid_reg.sv
// dp_skid_reg: two-entry skid-buffered pipeline register; stall counter enabled by DP_SKID_STALL_CNT_EN.
module dp_skid_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             acc, emit;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state)
      EMPTY: if (acc) begin
        state_d = BUSY;
        main_d  = in_data;
      end
      BUSY: if (acc && emit) main_d = in_data;
      else if (acc) begin
        state_d = FULL;
        skid_d  = in_data;
      end
      else if (emit) state_d = EMPTY;
      FULL: if (emit) begin
        state_d = BUSY;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush overrides any handshake in the same cycle
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
`ifdef DP_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (out_valid && !out_ready && !flush && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
